pack_4_nums: RTL and testbench

- Serial-to-parallel operand packer. It drives the operand side of the 4-operand adder interface (enable plus a/b/c/d) from a byte stream.
- It accepts one operand per beat on a valid/ready input and groups four beats into a bundle.
- It presents each bundle on o_a..o_d with o_enable. It also carries a registered reference sum, so benches can check the adder's o_sum.
- It sits between a stream source (FIFO/UART/bench driver) and add_4_nums.

---
 rtl/pack_4_nums.sv | 97 +++++++++
 tb/tb_pack_4_nums.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pack_4_nums.sv
// +--------------------------------------------------------------------------+
// | pack_4_nums : serial-to-parallel operand packer for the 4-operand adder  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pack_4_nums #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_ready,
  output logic               o_enable,
  output logic [WIDTH-1:0]   o_a,
  output logic [WIDTH-1:0]   o_b,
  output logic [WIDTH-1:0]   o_c,
  output logic [WIDTH-1:0]   o_d,
  output logic [WIDTH+1:0]   o_sum_ref,
  output logic [1:0]         o_cnt
);

  localparam int SUM_W = WIDTH + 2;
  localparam logic [1:0] c_LAST = 2'd3;

  logic [1:0]       r_cnt;
  logic             r_enable;
  logic [WIDTH-1:0] r_stage0, r_stage1, r_stage2;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [SUM_W-1:0] r_sum;

  logic             w_ready;
  logic             w_accept;
  logic             w_complete;
  logic [SUM_W-1:0] w_sum;

  // Only the completing beat waits for the held bundle to drain.
  assign w_ready    = (r_cnt != c_LAST) || !r_enable || i_ready;
  assign w_accept   = i_valid && w_ready;
  assign w_complete = w_accept && (r_cnt == c_LAST) && !i_flush;
  assign w_sum      = SUM_W'(r_stage0) + SUM_W'(r_stage1)
                    + SUM_W'(r_stage2) + SUM_W'(i_data);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= 2'd0;
      r_enable <= 1'b0;
      r_stage0 <= '0;
      r_stage1 <= '0;
      r_stage2 <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_sum    <= '0;
    end else begin
      if (i_flush) begin
        r_cnt <= 2'd0;
      end else if (w_accept) begin
        case (r_cnt)
          2'd0:    r_stage0 <= i_data;
          2'd1:    r_stage1 <= i_data;
          2'd2:    r_stage2 <= i_data;
          default: begin
            r_a   <= r_stage0;
            r_b   <= r_stage1;
            r_c   <= r_stage2;
            r_d   <= i_data;
            r_sum <= w_sum;
          end
        endcase
        r_cnt <= r_cnt + 2'd1;
      end

      // A completion in the same cycle as a drain keeps the output valid.
      if (w_complete)
        r_enable <= 1'b1;
      else if (r_enable && i_ready)
        r_enable <= 1'b0;
    end
  end

  assign o_ready   = w_ready;
  assign o_enable  = r_enable;
  assign o_a       = r_a;
  assign o_b       = r_b;
  assign o_c       = r_c;
  assign o_d       = r_d;
  assign o_sum_ref = r_sum;
  assign o_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pack_4_nums.sv
// +--------------------------------------------------------------------------+
// | tb_pack_4_nums : directed self-checking bench for pack_4_nums            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pack_4_nums;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready_out;
  logic             ready_in;
  logic             enable;
  logic [WIDTH-1:0] a, b, c, d;
  logic [WIDTH+1:0] sum_ref;
  logic [1:0]       cnt;

  int errors = 0;
  int checks = 0;

  pack_4_nums #(.WIDTH(WIDTH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_data    (data),
    .i_valid   (valid),
    .o_ready   (ready_out),
    .i_ready   (ready_in),
    .o_enable  (enable),
    .o_a       (a),
    .o_b       (b),
    .o_c       (c),
    .o_d       (d),
    .o_sum_ref (sum_ref),
    .o_cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [WIDTH-1:0] v);
    valid = 1'b1;
    data  = v;
    tick();
  endtask

  task automatic idle();
    valid = 1'b0;
    tick();
  endtask

  task automatic chk_bundle(input string tag, input logic [7:0] ea, eb, ec, ed,
                            input logic [9:0] es);
    chk({tag, "_en"},  enable,  1);
    chk({tag, "_a"},   a,       ea);
    chk({tag, "_b"},   b,       eb);
    chk({tag, "_c"},   c,       ec);
    chk({tag, "_d"},   d,       ed);
    chk({tag, "_sum"}, sum_ref, es);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    data     = '0;
    valid    = 1'b0;
    ready_in = 1'b1;
    #12;
    chk("rst_en",  enable,  0);
    chk("rst_a",   a,       0);
    chk("rst_sum", sum_ref, 0);
    chk("rst_cnt", cnt,     0);
    rst = 1'b0;
    tick();
    chk("rel_ready", ready_out, 1);

    // Basic bundle 1,2,3,4
    beat(8'h01);
    beat(8'h02);
    chk("t1_cnt2", cnt, 2);
    beat(8'h03);
    chk("t1_en_pre", enable, 0);
    beat(8'h04);
    chk_bundle("t1", 8'h01, 8'h02, 8'h03, 8'h04, 10'd10);
    chk("t1_cnt0", cnt, 0);
    idle();
    chk("t1_drain", enable, 0);

    // Maximum operands, no truncation
    beat(8'hFF); beat(8'hFF); beat(8'hFF); beat(8'hFF);
    chk_bundle("t2", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h3FC);

    // Back-pressure: bundle held while the next three beats stage
    ready_in = 1'b0;
    beat(8'h11); beat(8'h22); beat(8'h33);
    chk("t3_cnt3", cnt, 3);
    chk_bundle("t3_hold", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h3FC);
    valid = 1'b1;
    data  = 8'h44;
    #1;
    chk("t3_stall_rdy", ready_out, 0);
    tick(); tick(); tick();
    chk("t3_stall_cnt", cnt, 3);
    chk_bundle("t3_stall", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h3FC);
    ready_in = 1'b1;
    #1;
    chk("t3_release_rdy", ready_out, 1);
    tick();
    chk_bundle("t3_b2", 8'h11, 8'h22, 8'h33, 8'h44, 10'h0AA);
    chk("t3_cnt0", cnt, 0);
    idle();
    chk("t3_drain", enable, 0);

    // Continuous stream of 12 beats -> 3 single-cycle bundles
    for (int i = 0; i < 12; i++) begin
      beat(8'(8'h30 + i));
      if ((i % 4) == 3) begin
        chk_bundle("t4", 8'(8'h30 + i - 3), 8'(8'h30 + i - 2), 8'(8'h30 + i - 1),
                   8'(8'h30 + i), 10'(4 * 8'h30 + 4 * i - 6));
      end else begin
        chk("t4_en_low", enable, 0);
      end
    end
    idle();
    chk("t4_drain", enable, 0);

    // Flush drops partial bundle and a beat offered in the same cycle
    beat(8'h55); beat(8'h66);
    chk("t5_cnt2", cnt, 2);
    flush = 1'b1;
    beat(8'h77);
    flush = 1'b0;
    chk("t5_flush_cnt", cnt, 0);
    chk("t5_flush_en", enable, 0);
    beat(8'h10); beat(8'h20); beat(8'h30); beat(8'h40);
    chk_bundle("t5", 8'h10, 8'h20, 8'h30, 8'h40, 10'h0A0);
    idle();

    // Async reset mid-operation with a held bundle and two staged beats
    ready_in = 1'b0;
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    beat(8'h05); beat(8'h06);
    chk("t6_pre_cnt", cnt, 2);
    chk("t6_pre_en", enable, 1);
    valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_en",  enable,  0);
    chk("t6_rst_a",   a,       0);
    chk("t6_rst_d",   d,       0);
    chk("t6_rst_sum", sum_ref, 0);
    chk("t6_rst_cnt", cnt,     0);
    tick();
    rst      = 1'b0;
    ready_in = 1'b1;
    beat(8'h0A); beat(8'h0B); beat(8'h0C); beat(8'h0D);
    chk_bundle("t6_post", 8'h0A, 8'h0B, 8'h0C, 8'h0D, 10'h02E);
    idle();
    chk("t6_drain", enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
